// File: rtl/la_clkgatectrl_if.sv
// Activity/request inputs and ICG control outputs of the idle-detect clock-gate controller.
// The master drives activity and the idle limit; the slave (controller) returns en/ack/gated.
interface la_clkgatectrl_if #(
  parameter int IDLEW = 8
);
  logic             busy;
  logic             req;
  logic             force_on;
  logic [IDLEW-1:0] idle_limit;
  logic             en;
  logic             ack;
  logic             gated;

  modport master (
    output busy, req, force_on, idle_limit,
    input  en, ack, gated
  );

  modport slave (
    input  busy, req, force_on, idle_limit,
    output en, ack, gated
  );
endinterface

// File: rtl/la_clkgatectrl.sv
// Idle-detect clock-gate controller: gates a domain clock after idle_limit idle cycles and
// re-enables it on activity, acknowledging once the clock has run WAKEDLY cycles.
module la_clkgatectrl #(
  parameter         PROP    = "DEFAULT",
  parameter int     IDLEW   = 8,
  parameter int     WAKEDLY = 2
) (
  input  logic              clk,
  input  logic              nreset,
  la_clkgatectrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  localparam logic [3:0] WAKE_LAST = 4'(WAKEDLY - 1);

  // PROP is a pass-through tag only; fold it into a deliberately unused net.
  logic w_unused_prop;
  assign w_unused_prop = |32'($bits(PROP));

  state_t           r_state;
  state_t           w_state_next;
  logic [IDLEW-1:0] r_cnt;
  logic [IDLEW-1:0] w_cnt_next;
  logic [3:0]       r_wcnt;
  logic [3:0]       w_wcnt_next;
  logic             r_en;
  logic             r_ack;
  logic             r_gated;
  logic             w_idle;
  logic [IDLEW-1:0] w_limit_m1;

  assign w_idle     = !bus.busy && !bus.req && !bus.force_on;
  assign w_limit_m1 = bus.idle_limit - IDLEW'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wcnt_next  = r_wcnt;
    unique case (r_state)
      ST_RUN: begin
        if (!w_idle || bus.idle_limit == '0) begin
          w_cnt_next = '0;
        end else if (r_cnt >= w_limit_m1) begin
          // >= so that lowering idle_limit mid-count gates on the next idle edge
          w_state_next = ST_GATED;
          w_cnt_next   = '0;
        end else if (r_cnt != '1) begin
          w_cnt_next = r_cnt + IDLEW'(1);
        end
      end
      ST_GATED: begin
        if (!w_idle) begin
          w_state_next = ST_WAKE;
          w_wcnt_next  = '0;
        end
      end
      ST_WAKE: begin
        if (r_wcnt == WAKE_LAST) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
          w_wcnt_next  = '0;
        end else begin
          w_wcnt_next = r_wcnt + 4'd1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = '0;
        w_wcnt_next  = '0;
      end
    endcase
  end

  // Outputs decoded from the next state and flopped, so en only moves on posedge clk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_en    <= 1'b1;
      r_ack   <= 1'b1;
      r_gated <= 1'b0;
    end else begin
      r_en    <= (w_state_next != ST_GATED);
      r_ack   <= (w_state_next == ST_RUN);
      r_gated <= (w_state_next == ST_GATED);
    end
  end

  assign bus.en    = r_en;
  assign bus.ack   = r_ack;
  assign bus.gated = r_gated;

endmodule

// File: tb/tb_la_clkgatectrl.sv
// Scoreboard bench for la_clkgatectrl: driver pushes model outputs per cycle, monitor pops
// and compares on the falling edge.
module tb_la_clkgatectrl;

  localparam int IDLEW   = 8;
  localparam int WAKEDLY = 2;

  logic clk;
  logic nreset;

  la_clkgatectrl_if #(.IDLEW(IDLEW)) bus ();

  la_clkgatectrl #(
    .PROP    ("DEFAULT"),
    .IDLEW   (IDLEW),
    .WAKEDLY (WAKEDLY)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: clock on/off, settled flag, idle streak length, settle cycles remaining.
  bit   m_on;
  bit   m_settled;
  int   m_streak;
  int   m_left;
  bit   p_busy, p_req, p_force, p_rn;
  int   p_lim;

  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    m_on      = 1'b1;
    m_settled = 1'b1;
    m_streak  = 0;
    m_left    = 0;
  endfunction

  function automatic void model_edge();
    bit idle;
    if (!p_rn) begin
      model_reset();
      return;
    end
    idle = !(p_busy || p_req || p_force);
    if (!m_on) begin
      if (!idle) begin
        m_on      = 1'b1;
        m_settled = 1'b0;
        m_left    = WAKEDLY;
      end
    end else if (!m_settled) begin
      m_left--;
      if (m_left == 0) begin
        m_settled = 1'b1;
        m_streak  = 0;
      end
    end else begin
      if (!idle || p_lim == 0) m_streak = 0;
      else if (m_streak + 1 >= p_lim) begin
        m_on     = 1'b0;
        m_streak = 0;
      end else m_streak++;
    end
  endfunction

  task automatic step(input bit b, input bit r, input bit f, input int lim, input bit rn);
    @(posedge clk);
    model_edge();
    #1;
    bus.busy       = b;
    bus.req        = r;
    bus.force_on   = f;
    bus.idle_limit = IDLEW'(lim);
    nreset         = rn;
    p_busy = b; p_req = r; p_force = f; p_lim = lim; p_rn = rn;
    if (!rn) model_reset();
    exp_q.push_back({m_on, m_on && m_settled, !m_on});
  endtask

  task automatic idle_n(input int n, input int lim);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, lim, 1'b1);
  endtask

  // Monitor: outputs are presented every cycle, so one expected entry per falling edge.
  always @(negedge clk) begin
    logic [2:0] e;
    logic [2:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.en, bus.ack, bus.gated};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t en/ack/gated got %b%b%b want %b%b%b",
                 $time, a[2], a[1], a[0], e[2], e[1], e[0]);
      end else begin
        $display("chk t=%0t en/ack/gated=%b%b%b", $time, a[2], a[1], a[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    bus.busy = 1'b0; bus.req = 1'b0; bus.force_on = 1'b0;
    bus.idle_limit = IDLEW'(4);
    nreset = 1'b0;
    p_busy = 0; p_req = 0; p_force = 0; p_lim = 4; p_rn = 0;
    model_reset();

    // Reset, then gate after 4 idle edges.
    step(0, 0, 0, 4, 0);
    step(0, 0, 0, 4, 0);
    idle_n(8, 4);
    // Single-cycle req wakes; ack after WAKEDLY; then gates again.
    step(0, 1, 0, 4, 1);
    idle_n(10, 4);
    // idle_limit=0 never gates over 300 idle cycles.
    step(0, 1, 0, 0, 1);
    idle_n(300, 0);
    // Busy every 3rd cycle never gates.
    for (int i = 0; i < 60; i++) step(i % 3 == 0, 0, 0, 4, 1);
    // Limit drop from 200 to 2 after a long idle run gates on the next idle edge.
    idle_n(51, 200);
    idle_n(4, 2);
    // Handover req->busy on the same edge is activity.
    step(0, 1, 0, 2, 1);
    step(1, 0, 0, 2, 1);
    idle_n(6, 2);
    // force_on wakes from GATED, and held high keeps RUN.
    step(0, 0, 1, 4, 1);
    idle_n(6, 4);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 4, 1);
    idle_n(6, 4);
    // Reset during WAKE (wcnt=0), then during GATED.
    step(0, 1, 0, 4, 1);
    step(0, 0, 0, 4, 0);
    idle_n(6, 4);
    step(0, 0, 0, 4, 0);
    idle_n(8, 4);
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(5))
        0: lim = 0;
        1: lim = 1;
        2: lim = 2;
        3: lim = 3;
        4: lim = 5;
        default: lim = 8;
      endcase
      step($urandom_range(99) < 12, $urandom_range(99) < 8, $urandom_range(99) < 4,
           lim, $urandom_range(199) != 0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending entries got %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
